// File: rtl/iic_pkg.sv
// Shared definitions for the I2C target: FSM state encoding, bus bit
// meanings and the default device address.
package iic_pkg;

  localparam logic [6:0] DEV_ADDR_DEF = 7'h3C;
  localparam logic       ACK          = 1'b0;
  localparam logic       NACK         = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV       = 4'd1,
    ST_DEV_ACK   = 4'd2,
    ST_REG_H     = 4'd3,
    ST_REG_H_ACK = 4'd4,
    ST_REG_L     = 4'd5,
    ST_REG_L_ACK = 4'd6,
    ST_WR_BYTE   = 4'd7,
    ST_WR_ACK    = 4'd8,
    ST_RD_BYTE   = 4'd9,
    ST_RD_MACK   = 4'd10,
    ST_WAIT_STOP = 4'd11
  } iic_state_e;

endpackage

// File: rtl/iic_in_filter.sv
// Brings one asynchronous bus line into the clock domain, rejects glitches
// shorter than FILT_LEN samples and produces single-cycle edge pulses.
module iic_in_filter #(
  parameter int FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic [1:0]    r_sync;
  logic          r_filt;
  logic          r_prev;
  logic [CW-1:0] r_cnt;

  // r_cnt counts consecutive samples that disagree with the filtered level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= 2'b11;
      r_filt <= 1'b1;
      r_prev <= 1'b1;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_async};
      r_prev <= r_filt;
      if (r_sync[1] == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT_LEN - 1)) begin
        r_filt <= r_sync[1];
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_level = r_filt;
  assign o_rise  = r_filt & ~r_prev;
  assign o_fall  = ~r_filt & r_prev;

endmodule

// File: rtl/iic_slave_resp.sv
// I2C target with a 16-bit auto-incrementing register address, driving a
// single-cycle register-file port (wr_en / rd_req) toward local logic.
module iic_slave_resp
  import iic_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
  parameter int         FILT_LEN = 3
) (
  input  logic        clk_8m,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic [15:0] reg_addr,
  output logic        wr_en,
  output logic [7:0]  wr_data,
  output logic        rd_req,
  input  logic [7:0]  rd_data,
  output logic        busy,
  output logic        err,
  output logic [3:0]  dbg_state
);

  logic w_scl, w_scl_rise, w_scl_fall;
  logic w_sda, w_sda_rise, w_sda_fall;

  iic_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk(clk_8m), .rst(rst), .i_async(scl_i),
    .o_level(w_scl), .o_rise(w_scl_rise), .o_fall(w_scl_fall)
  );

  iic_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk(clk_8m), .rst(rst), .i_async(sda_i),
    .o_level(w_sda), .o_rise(w_sda_rise), .o_fall(w_sda_fall)
  );

  iic_state_e  r_state, w_next_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_phase;   // ACK states: ACK-bit rise seen; RD_BYTE: 8 bits sent; RD_MACK: master ACKed
  logic        r_rw;
  logic        r_rd_lat;
  logic        r_sda_oe;
  logic [15:0] r_reg_addr;
  logic        r_wr_en;
  logic [7:0]  r_wr_data;
  logic        r_rd_req;
  logic        r_busy;
  logic        r_err;

  logic       w_start, w_stop;
  logic       w_rx_state, w_ack_state, w_data_state;
  logic       w_byte_done, w_rd_mode, w_mid_byte;
  logic [7:0] w_byte;

  assign w_start = w_sda_fall & w_scl;
  assign w_stop  = w_sda_rise & w_scl;

  assign w_rx_state   = (r_state == ST_DEV) || (r_state == ST_REG_H) ||
                        (r_state == ST_REG_L) || (r_state == ST_WR_BYTE);
  assign w_ack_state  = (r_state == ST_DEV_ACK) || (r_state == ST_REG_H_ACK) ||
                        (r_state == ST_REG_L_ACK) || (r_state == ST_WR_ACK);
  assign w_data_state = (r_state == ST_REG_H) || (r_state == ST_REG_L) ||
                        (r_state == ST_WR_BYTE) || (r_state == ST_RD_BYTE);
  assign w_byte      = {r_shift[6:0], w_sda};
  assign w_byte_done = w_rx_state & w_scl_rise & (r_bit_cnt == 3'd7);
  assign w_rd_mode   = (r_state == ST_DEV_ACK) & r_rw;
  // A legal START/STOP always follows one SCL rise of the next bit slot,
  // so only two or more bits in counts as an interrupted byte.
  assign w_mid_byte  = r_busy & w_data_state & (r_bit_cnt > 3'd1);

  always_comb begin
    w_next_state = r_state;
    if (w_stop) begin
      w_next_state = ST_IDLE;
    end else if (w_start) begin
      w_next_state = ST_DEV;
    end else begin
      case (r_state)
        ST_DEV:       if (w_byte_done) w_next_state = (w_byte[7:1] == DEV_ADDR) ? ST_DEV_ACK : ST_WAIT_STOP;
        ST_DEV_ACK:   if (w_scl_fall && r_phase) w_next_state = r_rw ? ST_RD_BYTE : ST_REG_H;
        ST_REG_H:     if (w_byte_done) w_next_state = ST_REG_H_ACK;
        ST_REG_H_ACK: if (w_scl_fall && r_phase) w_next_state = ST_REG_L;
        ST_REG_L:     if (w_byte_done) w_next_state = ST_REG_L_ACK;
        ST_REG_L_ACK: if (w_scl_fall && r_phase) w_next_state = ST_WR_BYTE;
        ST_WR_BYTE:   if (w_byte_done) w_next_state = ST_WR_ACK;
        ST_WR_ACK:    if (w_scl_fall && r_phase) w_next_state = ST_WR_BYTE;
        ST_RD_BYTE:   if (w_scl_fall && r_phase) w_next_state = ST_RD_MACK;
        ST_RD_MACK: begin
          if (w_scl_rise && (w_sda == NACK)) w_next_state = ST_WAIT_STOP;
          else if (w_scl_fall && r_phase)    w_next_state = ST_RD_BYTE;
        end
        default:      w_next_state = r_state;
      endcase
    end
  end

  always_ff @(posedge clk_8m or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'd0;
      r_phase    <= 1'b0;
      r_rw       <= 1'b0;
      r_rd_lat   <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_reg_addr <= 16'd0;
      r_wr_en    <= 1'b0;
      r_wr_data  <= 8'd0;
      r_rd_req   <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_wr_en  <= 1'b0;
      r_rd_req <= 1'b0;
      r_rd_lat <= r_rd_req;
      if (r_rd_lat) r_shift <= rd_data;
      if (r_wr_en)  r_reg_addr <= r_reg_addr + 16'd1;

      if (w_stop || w_start) begin
        r_sda_oe  <= 1'b0;
        r_bit_cnt <= 3'd0;
        r_phase   <= 1'b0;
        if (w_mid_byte) r_err  <= 1'b1;
        if (w_stop)     r_busy <= 1'b0;
      end else begin
        if (w_rx_state && w_scl_rise) begin
          r_shift   <= w_byte;
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end

        if (w_byte_done) begin
          case (r_state)
            ST_DEV: begin
              r_rw <= w_sda;
              if (w_byte[7:1] == DEV_ADDR) begin
                r_busy <= 1'b1;
                r_err  <= 1'b0;
              end else begin
                r_busy <= 1'b0;
              end
            end
            ST_REG_H:   r_reg_addr[15:8] <= w_byte;
            ST_REG_L:   r_reg_addr[7:0]  <= w_byte;
            ST_WR_BYTE: begin
              r_wr_en   <= 1'b1;
              r_wr_data <= w_byte;
            end
            default: ;
          endcase
        end

        // ACK bit: drive after the byte's last fall, release (or present
        // the first read bit) after the ACK bit's own fall.
        if (w_ack_state) begin
          if (w_scl_rise) begin
            r_phase <= 1'b1;
            if (w_rd_mode) r_rd_req <= 1'b1;
          end
          if (w_scl_fall) begin
            if (!r_phase) begin
              r_sda_oe <= 1'b1;
            end else begin
              r_phase   <= 1'b0;
              r_bit_cnt <= 3'd0;
              r_sda_oe  <= w_rd_mode ? ~r_shift[7] : 1'b0;
            end
          end
        end

        if (r_state == ST_RD_BYTE) begin
          if (w_scl_rise) begin
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_phase <= 1'b1;
          end
          if (w_scl_fall) begin
            if (r_phase) begin
              r_phase  <= 1'b0;
              r_sda_oe <= 1'b0;
            end else begin
              r_shift  <= {r_shift[6:0], 1'b0};
              r_sda_oe <= ~r_shift[6];
            end
          end
        end

        if (r_state == ST_RD_MACK) begin
          if (w_scl_rise && (w_sda == ACK)) begin
            r_phase    <= 1'b1;
            r_reg_addr <= r_reg_addr + 16'd1;
            r_rd_req   <= 1'b1;
          end
          if (w_scl_fall && r_phase) begin
            r_phase   <= 1'b0;
            r_bit_cnt <= 3'd0;
            r_sda_oe  <= ~r_shift[7];
          end
        end
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign reg_addr  = r_reg_addr;
  assign wr_en     = r_wr_en;
  assign wr_data   = r_wr_data;
  assign rd_req    = r_rd_req;
  assign busy      = r_busy;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_iic_slave_resp.sv
// Bench for iic_slave_resp: bit-banged I2C master, local register file,
// and a scoreboard on the register-port transactions.
`timescale 1ns/1ps
module tb_iic_slave_resp;
  import iic_pkg::*;

  localparam int Q = 10;  // quarter SCL period in clk_8m cycles

  logic        clk_8m = 1'b0;
  logic        rst    = 1'b1;
  logic        scl_m  = 1'b1;
  logic        sda_m  = 1'b1;
  logic        scl_glitch = 1'b0;
  logic        scl_i, sda_i, sda_line;
  logic        sda_oe, wr_en, rd_req, busy, err;
  logic [15:0] reg_addr;
  logic [7:0]  wr_data;
  logic [7:0]  rd_data = 8'd0;
  logic [3:0]  dbg_state;

  int n_vec  = 0;
  int n_miss = 0;

  logic [23:0] exp_wr_q[$];
  logic [15:0] exp_rd_q[$];
  logic [7:0]  model_mem [int];
  logic [7:0]  rf [int];
  logic [7:0]  tb_d [4];

  assign sda_line = sda_m & ~sda_oe;
  assign sda_i    = sda_line;
  assign scl_i    = scl_m ^ scl_glitch;

  always #5 clk_8m = ~clk_8m;

  iic_slave_resp dut (
    .clk_8m(clk_8m), .rst(rst), .scl_i(scl_i), .sda_i(sda_i),
    .sda_oe(sda_oe), .reg_addr(reg_addr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_req(rd_req), .rd_data(rd_data), .busy(busy), .err(err),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hC3;
  endfunction

  function automatic logic [7:0] model_rd(input logic [15:0] a);
    return model_mem.exists(int'(a)) ? model_mem[int'(a)] : init_val(a);
  endfunction

  // Local register file answering the DUT port.
  always @(negedge clk_8m) begin
    if (!rst && wr_en) rf[int'(reg_addr)] = wr_data;
    if (!rst && rd_req) rd_data = rf.exists(int'(reg_addr)) ? rf[int'(reg_addr)] : init_val(reg_addr);
  end

  // Scoreboard monitor.
  always @(negedge clk_8m) begin
    if (!rst && (wr_en || rd_req)) begin
      chk("wr_rd_excl", {31'd0, wr_en & rd_req}, 32'd0);
      if (wr_en) begin
        if (exp_wr_q.size() == 0) chk("wr_unexpected", {8'd0, reg_addr, wr_data}, 32'hFFFFFFFF);
        else chk("wr_txn", {8'd0, reg_addr, wr_data}, {8'd0, exp_wr_q.pop_front()});
      end
      if (rd_req) begin
        if (exp_rd_q.size() == 0) chk("rd_unexpected", {16'd0, reg_addr}, 32'hFFFFFFFF);
        else chk("rd_txn", {16'd0, reg_addr}, {16'd0, exp_rd_q.pop_front()});
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wq(input int n);
    repeat (n) @(negedge clk_8m);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wq(Q);
    scl_m = 1'b1; wq(Q);
    sda_m = 1'b1; wq(Q);
  endtask

  task automatic send_bit(input logic b, input bit glitch, output logic s);
    sda_m = b;
    if (glitch) begin
      wq(3); scl_glitch = 1'b1; wq(1); scl_glitch = 1'b0; wq(Q - 4);
    end else begin
      wq(Q);
    end
    scl_m = 1'b1; wq(Q);
    s = sda_line; wq(Q);
    scl_m = 1'b0; wq(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit glitch, output logic acked);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], glitch && (i == 4), s);
    send_bit(1'b1, 1'b0, s);
    acked = ~s;
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d, output logic released);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      send_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    send_bit(mack, 1'b0, s);
    released = (s == mack);
  endtask

  task automatic addr_phase(input logic [15:0] a);
    logic ack;
    bus_start();
    write_byte({DEV_ADDR_DEF, 1'b0}, 1'b0, ack); chk("dev_ack_w", {31'd0, ack}, 32'd1);
    chk("busy_addressed", {31'd0, busy}, 32'd1);
    write_byte(a[15:8], 1'b0, ack); chk("regh_ack", {31'd0, ack}, 32'd1);
    write_byte(a[7:0], 1'b0, ack);  chk("regl_ack", {31'd0, ack}, 32'd1);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d [4], input int n, input bit glitch);
    logic ack;
    logic [15:0] p;
    addr_phase(a);
    p = a;
    for (int i = 0; i < n; i++) begin
      exp_wr_q.push_back({p, d[i]});
      model_mem[int'(p)] = d[i];
      p = p + 16'd1;
      write_byte(d[i], glitch && (i == 0), ack);
      chk("data_ack", {31'd0, ack}, 32'd1);
    end
    bus_stop();
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
    chk("err_clean", {31'd0, err}, 32'd0);
  endtask

  task automatic do_read(input logic [15:0] a, input int n);
    logic ack, rel;
    logic [7:0] got;
    addr_phase(a);
    bus_start();
    exp_rd_q.push_back(a);
    write_byte({DEV_ADDR_DEF, 1'b1}, 1'b0, ack); chk("dev_ack_r", {31'd0, ack}, 32'd1);
    for (int i = 0; i < n; i++) begin
      if (i < n - 1) exp_rd_q.push_back(a + 16'(i + 1));
      read_byte((i == n - 1) ? 1'b1 : 1'b0, got, rel);
      chk("rd_byte", {24'd0, got}, {24'd0, model_rd(a + 16'(i))});
      chk("mack_released", {31'd0, rel}, 32'd1);
    end
    chk("oe_after_nack", {31'd0, sda_oe}, 32'd0);
    bus_stop();
    chk("busy_after_rd", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic ack, s;
    logic [15:0] a;
    int n;

    wq(3);
    chk("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_reg_addr", {16'd0, reg_addr}, 32'd0);
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    wq(5);
    chk("rst_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});

    // Single write, then read-back over a repeated START.
    tb_d[0] = 8'hA5;
    do_write(16'h1234, tb_d, 1, 1'b0);
    rf[16'h1234] = 8'h5A;
    model_mem[16'h1234] = 8'h5A;
    do_read(16'h1234, 1);

    // Burst across the address wrap.
    tb_d[0] = 8'h11; tb_d[1] = 8'h22; tb_d[2] = 8'h33;
    do_write(16'hFFFF, tb_d, 3, 1'b0);
    do_read(16'hFFFF, 2);

    // Address mismatch: no ACK, not busy; the next START is served.
    bus_start();
    write_byte(8'h50, 1'b0, ack);
    chk("mismatch_nack", {31'd0, ack}, 32'd0);
    chk("mismatch_busy", {31'd0, busy}, 32'd0);
    write_byte(8'h78, 1'b0, ack);
    chk("wait_stop_nack", {31'd0, ack}, 32'd0);
    tb_d[0] = 8'h3E;
    do_write(16'h0042, tb_d, 1, 1'b0);

    // STOP after 4 bits of a data byte.
    addr_phase(16'h0100);
    for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0, s);
    bus_stop();
    chk("partial_err", {31'd0, err}, 32'd1);
    chk("partial_state", {28'd0, dbg_state}, {28'd0, ST_IDLE});
    chk("partial_busy", {31'd0, busy}, 32'd0);

    // One-cycle SCL glitch mid-byte is filtered out.
    tb_d[0] = 8'hC6; tb_d[1] = 8'h9D;
    do_write(16'h0200, tb_d, 2, 1'b1);

    // Reset during the ACK of the register-high byte.
    bus_start();
    write_byte(8'h78, 1'b0, ack);
    for (int i = 7; i >= 0; i--) send_bit(i[0], 1'b0, s);
    sda_m = 1'b1; wq(Q);
    scl_m = 1'b1; wq(2);
    chk("ack_before_rst", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_async_oe", {31'd0, sda_oe}, 32'd0);
    chk("rst_async_busy", {31'd0, busy}, 32'd0);
    chk("rst_async_addr", {16'd0, reg_addr}, 32'd0);
    wq(2);
    rst = 1'b0;
    wq(Q);
    scl_m = 1'b0; wq(Q);
    bus_stop();
    tb_d[0] = 8'h77;
    do_write(16'h0300, tb_d, 1, 1'b0);
    do_read(16'h0300, 1);

    // Randomized write / read-back transactions.
    for (int t = 0; t < 5; t++) begin
      a = (t == 0) ? 16'hFFFE : 16'($urandom_range(0, 65535));
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) tb_d[i] = 8'($urandom_range(0, 255));
      do_write(a, tb_d, n, 1'b0);
      do_read(a, $urandom_range(1, n));
    end

    wq(20);
    chk("wr_q_drained", exp_wr_q.size(), 32'd0);
    chk("rd_q_drained", exp_rd_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
